// File: rtl/cyc_counter5_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cyc_counter5_monitor_pkg
// Brief   : Shared types and defaults for the cyclic step-index monitor and
//           the prescaled step counter that feeds it.
// Revision: 1.0 - initial release
// ============================================================================
package cyc_counter5_monitor_pkg;

  // Defaults shared with the source counter
  localparam int unsigned DEF_COUNT     = 5;
  localparam int unsigned DEF_CYCLE2ONE = 10;
  localparam int unsigned DEF_SLACK     = 2;
  localparam int unsigned DEF_SIZE_CNT  = 3;
  localparam int unsigned DEF_SIZE_LAP  = 8;

  // Monitor state encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_FAULT   = 2'd3
  } mon_state_t;

  // Index that legally follows cur, wrapping from cnt-1 back to 0
  function automatic int unsigned next_idx(input int unsigned cur, input int unsigned cnt);
    return (cur == cnt - 1) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cyc_counter5_monitor_if.sv
`default_nettype none
// ============================================================================
// Module  : cyc_counter5_monitor_if
// Brief   : Bundle of control, index and status signals of the step-index
//           monitor. master = driver of index/controls, slave = monitor.
// Revision: 1.0 - initial release
// ============================================================================
interface cyc_counter5_monitor_if
  import cyc_counter5_monitor_pkg::*;
#(
  parameter int unsigned SIZE_CNT = DEF_SIZE_CNT,
  parameter int unsigned SIZE_LAP = DEF_SIZE_LAP
);
  logic                en;
  logic                clr;
  logic [SIZE_CNT-1:0] idx_in;
  logic                step_pulse;
  logic                wrap_pulse;
  logic                locked;
  logic                fault;
  logic                stall;
  logic [SIZE_LAP-1:0] lap_cnt;
  logic [SIZE_LAP-1:0] err_cnt;

  modport master (
    output en, clr, idx_in,
    input  step_pulse, wrap_pulse, locked, fault, stall, lap_cnt, err_cnt
  );

  modport slave (
    input  en, clr, idx_in,
    output step_pulse, wrap_pulse, locked, fault, stall, lap_cnt, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cyc_counter5_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : cyc_sat_counter
// Brief   : Up-counter with increment enable that sticks at all-ones.
// Revision: 1.0 - initial release
// ============================================================================
module cyc_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              inc,
  output logic [WIDTH-1:0] count
);

  // Count on inc until the all-ones ceiling is reached
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cyc_counter5_monitor.sv
`default_nettype none
// ============================================================================
// Module  : cyc_counter5_monitor
// Brief   : Receives the cyclic 0..COUNT-1 step index, emits step/wrap
//           pulses, counts laps, and flags illegal jumps, out-of-range
//           values and (optionally) stalls.
// Config  : CYC_MON_STALL_EN - enables the TRACK stall watchdog and the
//           stall flag; when undefined stall is tied low.
// Revision: 1.0 - initial release
// ============================================================================
module cyc_counter5_monitor
  import cyc_counter5_monitor_pkg::*;
#(
  parameter int unsigned CYCLE2ONE = DEF_CYCLE2ONE,
  parameter int unsigned SIZE_CYC  = 30,
  parameter int unsigned COUNT     = DEF_COUNT,
  parameter int unsigned SIZE_CNT  = DEF_SIZE_CNT,
  parameter int unsigned SIZE_LAP  = DEF_SIZE_LAP,
  parameter int unsigned SLACK     = DEF_SLACK
) (
  input wire                    clk,
  input wire                    rst,
  cyc_counter5_monitor_if.slave mon
);

  mon_state_t          state, state_nx;
  logic [SIZE_CNT-1:0] prev_idx, prev_idx_nx;
  logic                step_nx, wrap_nx, lap_inc, err_inc;
  logic                clear_flags, set_fault, set_stall;
  logic                step_q, wrap_q, locked_q, fault_q;
  logic                in_range, chg, legal;

  assign in_range = (32'(mon.idx_in) < COUNT);
  assign chg      = (mon.idx_in != prev_idx);
  assign legal    = in_range && (32'(mon.idx_in) == next_idx(32'(prev_idx), COUNT));

`ifdef CYC_MON_STALL_EN
  localparam logic [SIZE_CYC-1:0] STALL_LIMIT = SIZE_CYC'(CYCLE2ONE + SLACK);
  logic [SIZE_CYC-1:0] wdog;
  logic                wd_clear, wd_tick, stall_q;
`else
  logic [31:0] unused_stall_cfg;
  assign unused_stall_cfg = CYCLE2ONE + SLACK + SIZE_CYC;
`endif

  // Next-state, next-index and pulse decode; clr outranks index events
  always_comb begin
    state_nx    = state;
    prev_idx_nx = prev_idx;
    step_nx     = 1'b0;
    wrap_nx     = 1'b0;
    lap_inc     = 1'b0;
    err_inc     = 1'b0;
    clear_flags = 1'b0;
    set_fault   = 1'b0;
    set_stall   = 1'b0;
`ifdef CYC_MON_STALL_EN
    wd_clear    = 1'b0;
    wd_tick     = 1'b0;
`endif
    if (!mon.en) begin
      state_nx    = ST_IDLE;
      clear_flags = mon.clr;
    end else begin
      case (state)
        ST_IDLE: begin
          clear_flags = mon.clr;
          if (in_range) prev_idx_nx = mon.idx_in;
          state_nx = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          clear_flags = mon.clr;
          if (legal) begin
            prev_idx_nx = mon.idx_in;
            step_nx     = 1'b1;
            wrap_nx     = (mon.idx_in == '0);
            lap_inc     = (mon.idx_in == '0);
            state_nx    = ST_TRACK;
`ifdef CYC_MON_STALL_EN
            wd_clear    = 1'b1;
`endif
          end else if (chg && in_range) begin
            prev_idx_nx = mon.idx_in;
          end
        end
        ST_TRACK: begin
          if (mon.clr) begin
            clear_flags = 1'b1;
            prev_idx_nx = mon.idx_in;
            state_nx    = ST_ACQUIRE;
          end else if (legal) begin
            prev_idx_nx = mon.idx_in;
            step_nx     = 1'b1;
            wrap_nx     = (mon.idx_in == '0);
            lap_inc     = (mon.idx_in == '0);
`ifdef CYC_MON_STALL_EN
            wd_clear    = 1'b1;
`endif
          end else if (chg || !in_range) begin
            state_nx  = ST_FAULT;
            set_fault = 1'b1;
            err_inc   = 1'b1;
          end else begin
`ifdef CYC_MON_STALL_EN
            // Index has now been seen for wdog+1 cycles
            if (wdog >= STALL_LIMIT - SIZE_CYC'(1)) begin
              state_nx  = ST_FAULT;
              set_fault = 1'b1;
              set_stall = 1'b1;
              err_inc   = 1'b1;
            end else begin
              wd_tick = 1'b1;
            end
`endif
          end
        end
        ST_FAULT: begin
          if (mon.clr) begin
            clear_flags = 1'b1;
            prev_idx_nx = mon.idx_in;
            state_nx    = ST_ACQUIRE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // State, index history and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      prev_idx <= '0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      prev_idx <= prev_idx_nx;
      step_q   <= step_nx;
      wrap_q   <= wrap_nx;
      locked_q <= (state_nx == ST_TRACK);
      if (clear_flags)    fault_q <= 1'b0;
      else if (set_fault) fault_q <= 1'b1;
    end
  end

`ifdef CYC_MON_STALL_EN
  // Watchdog counts cycles the current index has been held; sticky stall flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog    <= '0;
      stall_q <= 1'b0;
    end else begin
      if (wd_clear)     wdog <= SIZE_CYC'(1);
      else if (wd_tick) wdog <= wdog + SIZE_CYC'(1);
      if (clear_flags)    stall_q <= 1'b0;
      else if (set_stall) stall_q <= 1'b1;
    end
  end
  assign mon.stall = stall_q;
`else
  assign mon.stall = 1'b0;
  logic unused_set_stall;
  assign unused_set_stall = set_stall;
`endif

  assign mon.step_pulse = step_q;
  assign mon.wrap_pulse = wrap_q;
  assign mon.locked     = locked_q;
  assign mon.fault      = fault_q;

  cyc_sat_counter #(.WIDTH(SIZE_LAP)) u_lap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lap_inc),
    .count (mon.lap_cnt)
  );

  cyc_sat_counter #(.WIDTH(SIZE_LAP)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (mon.err_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_cyc_counter5_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_cyc_counter5_monitor
// Brief   : Directed self-checking bench for cyc_counter5_monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cyc_counter5_monitor;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   steps_seen = 0;
  int   wraps_seen = 0;

  cyc_counter5_monitor_if bus ();

  cyc_counter5_monitor dut (
    .clk (clk),
    .rst (rst),
    .mon (bus.slave)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present index v for n clock edges, tallying pulses seen
  task automatic hold(input logic [2:0] v, input int n);
    bus.idx_in = v;
    for (int i = 0; i < n; i++) begin
      tick();
      steps_seen += int'(bus.step_pulse);
      wraps_seen += int'(bus.wrap_pulse);
    end
  endtask

  initial begin
    rst = 1'b0; bus.en = 1'b0; bus.clr = 1'b0; bus.idx_in = 3'd0;
    tick(); tick();
    check("rst_locked", int'(bus.locked), 0);
    check("rst_fault", int'(bus.fault), 0);
    check("rst_step", int'(bus.step_pulse), 0);
    check("rst_lap", int'(bus.lap_cnt), 0);
    check("rst_err", int'(bus.err_cnt), 0);

    // Acquire and run one full lap
    rst = 1'b1; bus.en = 1'b1;
    hold(3'd0, 10);
    check("acq_not_locked", int'(bus.locked), 0);
    steps_seen = 0; wraps_seen = 0;
    hold(3'd1, 1);
    check("first_step_pulse", int'(bus.step_pulse), 1);
    check("lock_after_step", int'(bus.locked), 1);
    hold(3'd1, 9); hold(3'd2, 10); hold(3'd3, 10); hold(3'd4, 10);
    check("lap_before_wrap", int'(bus.lap_cnt), 0);
    hold(3'd0, 1);
    check("wrap_pulse", int'(bus.wrap_pulse), 1);
    hold(3'd0, 9);
    check("steps_per_lap", steps_seen, 5);
    check("wraps_per_lap", wraps_seen, 1);
    check("lap_after_wrap", int'(bus.lap_cnt), 1);

    // Asynchronous reset in the middle of a cycle
    #2 rst = 1'b0;
    #1;
    check("async_rst_locked", int'(bus.locked), 0);
    check("async_rst_lap", int'(bus.lap_cnt), 0);
    #1 rst = 1'b1;

    // Skip fault then recovery through clr
    hold(3'd0, 3); hold(3'd1, 3);
    check("track_again", int'(bus.locked), 1);
    hold(3'd3, 1);
    check("skip_fault", int'(bus.fault), 1);
    check("skip_unlocked", int'(bus.locked), 0);
    check("skip_err", int'(bus.err_cnt), 1);
    check("skip_no_step", int'(bus.step_pulse), 0);
    hold(3'd3, 3);
    bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    check("clr_fault", int'(bus.fault), 0);
    check("clr_acquire", int'(bus.locked), 0);
    hold(3'd4, 1);
    check("relock_34", int'(bus.locked), 1);
    check("relock_step", int'(bus.step_pulse), 1);

    // Out-of-range values
    hold(3'd6, 1);
    check("oor_fault", int'(bus.fault), 1);
    check("oor_err", int'(bus.err_cnt), 2);
    bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    hold(3'd7, 2);
    check("oor_acq_ignored", int'(bus.fault), 0);
    check("oor_acq_unlocked", int'(bus.locked), 0);
    hold(3'd0, 1); hold(3'd1, 1);
    check("relock_01", int'(bus.locked), 1);

    // Lap counter saturation
    wraps_seen = 0;
    for (int lap = 0; lap < 260; lap++) begin
      hold(3'd2, 1); hold(3'd3, 1); hold(3'd4, 1); hold(3'd0, 1); hold(3'd1, 1);
    end
    check("lap_saturated", int'(bus.lap_cnt), 255);
    check("wraps_260", wraps_seen, 260);
    check("sat_no_fault", int'(bus.fault), 0);

    // Enable and clr priority
    bus.en = 1'b0; tick();
    check("en_off_unlocked", int'(bus.locked), 0);
    check("en_off_lap_held", int'(bus.lap_cnt), 255);
    check("en_off_err_held", int'(bus.err_cnt), 2);
    bus.en = 1'b1;
    hold(3'd1, 1); hold(3'd2, 1);
    check("en_relock", int'(bus.locked), 1);
    bus.clr = 1'b1; hold(3'd4, 1); bus.clr = 1'b0;
    check("clr_beats_jump_fault", int'(bus.fault), 0);
    check("clr_beats_jump_acq", int'(bus.locked), 0);
    check("clr_beats_jump_err", int'(bus.err_cnt), 2);
    hold(3'd0, 1);
    check("acq_from_4_lock", int'(bus.locked), 1);
    check("acq_from_4_wrap", int'(bus.wrap_pulse), 1);
    hold(3'd2, 1);
    check("jump_02_fault", int'(bus.fault), 1);
    check("jump_02_err", int'(bus.err_cnt), 3);
    bus.en = 1'b0; bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    check("en0_clr_fault", int'(bus.fault), 0);
    check("en0_clr_unlocked", int'(bus.locked), 0);

    // Stall watchdog
    bus.en = 1'b1;
    hold(3'd2, 1); hold(3'd3, 1);
    check("stall_setup_lock", int'(bus.locked), 1);
    hold(3'd3, 10);
    hold(3'd4, 1);
    check("held11_step", int'(bus.step_pulse), 1);
    check("held11_no_fault", int'(bus.fault), 0);
`ifdef CYC_MON_STALL_EN
    hold(3'd4, 10);
    check("held11_still_ok", int'(bus.fault), 0);
    hold(3'd4, 1);
    check("held12_fault", int'(bus.fault), 1);
    check("held12_stall", int'(bus.stall), 1);
    check("held12_err", int'(bus.err_cnt), 4);
    check("held12_unlocked", int'(bus.locked), 0);
`else
    hold(3'd4, 100);
    check("held100_no_fault", int'(bus.fault), 0);
    check("held100_locked", int'(bus.locked), 1);
    check("stall_tied_low", int'(bus.stall), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cyc_counter5_monitor.md
Name: cyc_counter5_monitor

Overview:
- Receiving end of the cyclic step index produced by the prescaled 0..COUNT-1 step counter. The index drives the animation-frame step in the boxing display path.
- Samples the index and decodes each legal advance into a one-cycle step pulse.
- Decodes each wrap (COUNT-1 -> 0) into a wrap pulse and a lap count.
- Detects illegal jumps, out-of-range values and stalls, so display logic can trust the frame index.

Parameters:
- cycle2one, 10, clock cycles per index step at the source.
- size_cyc, 30, width of the internal stall watchdog counter.
- count, 5, number of index values (0..count-1).
- size_cnt, 3, width of the index input.
- size_lap, 8, width of the lap and error counters.
- slack, 2, extra cycles tolerated beyond cycle2one before a stall is declared.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  monitor enable.
- clr  in  1  one-cycle pulse; clears fault and restarts acquisition.
- idx_in  in  size_cnt  step index from the source counter.
- step_pulse  out  1  one cycle high per legal advance.
- wrap_pulse  out  1  one cycle high when a legal advance lands on 0.
- locked  out  1  high while in TRACK.
- fault  out  1  sticky error flag.
- stall  out  1  sticky; set when the fault cause is a timeout.
- lap_cnt  out  size_lap  completed laps, saturating.
- err_cnt  out  size_lap  faults detected, saturating.

Behaviour:
- Reset: rst low asynchronously forces state IDLE and clears prev_idx, the watchdog and every output to 0.
- All outputs are registered.
- Latency: step_pulse and wrap_pulse assert in the cycle after the clock edge at which the changed idx_in is sampled.
- Definitions:
  - chg = (idx_in != prev_idx).
  - legal = idx_in == (prev_idx == count-1 ? 0 : prev_idx+1), and idx_in < count.
- IDLE: entered from any state when en=0.
  - locked=0; fault, stall and both counters hold.
  - When en=1, load prev_idx from idx_in (only if idx_in < count) and go to ACQUIRE.
- ACQUIRE:
  - Legal chg: prev_idx <= idx_in, step_pulse=1 (wrap_pulse/lap_cnt as in TRACK), go to TRACK.
  - Illegal in-range chg: reload prev_idx, stay in ACQUIRE, no fault.
  - Out-of-range idx_in: ignored.
  - Watchdog is inactive.
- TRACK: locked=1.
  - Legal chg: step_pulse=1, update prev_idx, clear the watchdog.
  - If the new idx_in is 0, also wrap_pulse=1 and lap_cnt increments, saturating at all-ones.
  - Illegal chg or idx_in >= count: go to FAULT, fault=1, err_cnt increments (saturating).
  - No chg: watchdog increments.
- FAULT: locked=0; no pulses; fault stays high until clr or reset.
- clr:
  - In FAULT or TRACK: clears fault and stall, reloads prev_idx from idx_in, goes to ACQUIRE.
  - In ACQUIRE or IDLE: clears the flags only.
  - clr wins over a simultaneous illegal change.
  - Counters are cleared only by rst.
- en=0 together with clr: flags clear, state goes to IDLE.
- Wrap-around: count-1 -> 0 is legal. Any other decrease, a repeat, or a skip (e.g. 1 -> 3) is illegal.

Optional Feature:
- Macro: CYC_MON_STALL_EN.
- Defined:
  - In TRACK the watchdog counts cycles since the last legal change.
  - When it reaches cycle2one+slack with no chg: go to FAULT, fault=1, stall=1, err_cnt increments.
- Undefined:
  - No watchdog register; stall is tied to 0.
  - TRACK waits indefinitely for a change.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, ACQUIRE, TRACK, FAULT);
  - default values for count, cycle2one and slack, shared with the source counter;
  - the next-index function (wrap at count-1).
- One natural sub-module, cyc_sat_counter: a parameterised saturating counter with enable, instantiated for lap_cnt and err_cnt.

Test Plan:
1. Reset/acquire: rst low mid-run -> all outputs 0 immediately. Release with en=1, idx 0..4 each held 10 cycles -> locked rises one cycle after the 0->1 sample; five step_pulses per lap; lap_cnt=1 after 4->0 with wrap_pulse.
2. Skip fault: in TRACK, idx goes 1->3 -> fault=1, locked=0, err_cnt=1, no step_pulse. Then clr while idx=3 -> ACQUIRE; 3->4 -> TRACK.
3. Out-of-range: idx_in=6 in TRACK -> FAULT. idx_in=7 in ACQUIRE -> ignored, no fault.
4. Saturation: force 260 laps with size_lap=8 -> lap_cnt holds at 255, wrap_pulse still pulses.
5. Stall (CYC_MON_STALL_EN): idx held 12 cycles -> fault=stall=1 at cycle 12. Held 11 cycles then legal step -> no fault. Without the macro -> held 100 cycles, no fault.
6. Enable/clr priority: en=0 in TRACK -> IDLE, locked=0, lap_cnt held. clr coincident with an illegal jump -> no fault, state ACQUIRE.
